// File: rtl/aes_inv_key_sched_if.sv
// Round-key streaming interface between the AES-128 key scheduler and the decryptor datapath.
// The scheduler takes the slave side; the consumer (the datapath or a bench) takes the master side.
interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, rk_last
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_round, rk_last
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Sequential AES-128 key scheduler: expands the cipher key forward to K[ROUNDS], one round per cycle,
// then streams K[ROUNDS]..K[0] with one inverse key-schedule step per accepted key.
module aes_inv_key_sched #(
  parameter int ROUNDS = 10
) (
  input logic               clk,
  input logic               rst_n,
  aes_inv_key_sched_if.slave kif
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, EMIT = 2'd2} state_t;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  // Forward AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_rot(k[31:0]) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: recover the trailing words first, then w0 from the recovered w3.
  function automatic logic [127:0] inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   rnd;
  logic         busy, rk_valid, rk_last;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  logic [3:0]   rnd_inc, rnd_dec;
  logic [127:0] fwd_key, inv_key;

  assign rnd_inc = rnd + 4'd1;
  assign rnd_dec = rnd - 4'd1;
  assign fwd_key = fwd(key_reg, rcon(rnd_inc));
  assign inv_key = inv(key_reg, rcon(rnd));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_reg  <= '0;
      rnd      <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_round <= '0;
      rk_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (kif.start) begin
            key_reg <= kif.key_in;
            rnd     <= '0;
            busy    <= 1'b1;
            state   <= EXPAND;
          end
        end
        EXPAND: begin
          key_reg <= fwd_key;
          rnd     <= rnd_inc;
          if (rnd_inc == LAST_RND) begin
            state    <= EMIT;
            rk_valid <= 1'b1;
            rk_out   <= fwd_key;
            rk_round <= rnd_inc;
            rk_last  <= 1'b0;
          end
        end
        EMIT: begin
          if (kif.rk_ready) begin
            if (rnd != 4'd0) begin
              key_reg  <= inv_key;
              rnd      <= rnd_dec;
              rk_out   <= inv_key;
              rk_round <= rnd_dec;
              rk_last  <= (rnd_dec == 4'd0);
            end else begin
              // rk_out/rk_round keep the K0 values after the job ends.
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kif.busy     = busy;
  assign kif.rk_valid = rk_valid;
  assign kif.rk_out   = rk_out;
  assign kif.rk_round = rk_round;
  assign kif.rk_last  = rk_last;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: stimulus pushes expected round keys, a negedge monitor
// pops and compares every accepted key and checks that outputs hold under backpressure.
module tb_aes_inv_key_sched;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         last;
    logic         chk_key;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic rnd_mode = 1'b0;
  exp_t q[$];

  logic         hold_pend = 1'b0;
  logic [127:0] hold_key;
  logic [3:0]   hold_rnd;

  aes_inv_key_sched_if kif();

  aes_inv_key_sched #(.ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_fips();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r); e.key = fips_rk[r]; e.last = (r == 0); e.chk_key = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic push_zero();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r); e.last = (r == 0);
      e.key = (r == 10) ? ZERO_K10 : 128'h0;
      e.chk_key = (r == 10) || (r == 0);
      q.push_back(e);
    end
  endtask

  task automatic kick(input logic [127:0] k);
    kif.start = 1'b1; kif.key_in = k;
    @(posedge clk); #1;
    kif.start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!kif.rk_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((kif.busy || q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("job_done_busy", 128'(kif.busy), 128'h0);
    chk("job_done_queue", 128'(q.size()), 128'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(kif.busy), 128'h0);
    chk({tag, "_valid"}, 128'(kif.rk_valid), 128'h0);
    chk({tag, "_out"}, kif.rk_out, 128'h0);
    chk({tag, "_round"}, 128'(kif.rk_round), 128'h0);
    chk({tag, "_last"}, 128'(kif.rk_last), 128'h0);
  endtask

  initial kif.rk_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    kif.rk_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: handshake is decided by the values seen half a cycle before the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 128'(kif.rk_valid), 128'h1);
        chk("hold_key", kif.rk_out, hold_key);
        chk("hold_round", 128'(kif.rk_round), 128'(hold_rnd));
      end
      hold_pend = kif.rk_valid && !kif.rk_ready;
      hold_key  = kif.rk_out;
      hold_rnd  = kif.rk_round;
      if (kif.rk_valid && kif.rk_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_key: got round %0d key %h, expected no output", kif.rk_round, kif.rk_out);
        end else begin
          e = q.pop_front();
          chk("rk_round", 128'(kif.rk_round), 128'(e.rnd));
          chk("rk_last", 128'(kif.rk_last), 128'(e.last));
          if (e.chk_key) chk($sformatf("rk_out_K%0d", e.rnd), kif.rk_out, e.key);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v;
    rst_n = 1'b0; kif.start = 1'b0; kif.key_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 key, always ready: latency, run length and retained K0.
    push_fips();
    kick(FIPS_KEY);
    wait_valid(n);
    chk("first_key_latency", 128'(n), 128'd10);
    v = 0;
    while (kif.rk_valid && v < 30) begin
      @(posedge clk); #1; v++;
    end
    chk("valid_run_length", 128'(v), 128'd11);
    chk("busy_after_k0", 128'(kif.busy), 128'h0);
    chk("retained_rk_out", kif.rk_out, FIPS_KEY);
    chk("retained_round", 128'(kif.rk_round), 128'h0);
    chk("last_cleared", 128'(kif.rk_last), 128'h0);
    chk("s1_queue", 128'(q.size()), 128'h0);

    // All-zero key.
    push_zero();
    kick('0);
    wait_idle(40);

    // Random backpressure.
    rnd_mode = 1'b1;
    push_fips();
    kick(FIPS_KEY);
    wait_idle(400);
    rnd_mode = 1'b0;
    @(posedge clk); #1;

    // start pulses during EXPAND and EMIT are ignored.
    push_fips();
    kick(FIPS_KEY);
    repeat (3) @(posedge clk);
    #1;
    kick(ALT_KEY);
    wait_valid(n);
    repeat (3) @(posedge clk);
    #1;
    kick(ALT_KEY);
    wait_idle(40);

    // Reset during EXPAND at rnd=5, with start held high under reset.
    push_fips();
    kick(FIPS_KEY);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; kif.start = 1'b1; kif.key_in = ALT_KEY; q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; kif.start = 1'b0;
    chk_reset_outputs("rst_expand");

    // Reset during EMIT at rnd=4.
    push_fips();
    kick(FIPS_KEY);
    n = 0;
    while (!(kif.rk_valid && kif.rk_round == 4'd4) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_emit_rnd4", 128'(kif.rk_round), 128'd4);
    rst_n = 1'b0; q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_outputs("rst_emit");

    push_fips();
    kick(FIPS_KEY);
    wait_idle(40);

    // Back-to-back: start held across the final handshake is taken one cycle later.
    push_fips();
    kick(FIPS_KEY);
    n = 0;
    while (!(kif.rk_valid && kif.rk_last) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    push_zero();
    kif.start = 1'b1; kif.key_in = '0;
    @(posedge clk); #1;
    chk("start_at_final_ignored", 128'(kif.busy), 128'h0);
    @(posedge clk); #1;
    kif.start = 1'b0;
    chk("start_next_cycle_taken", 128'(kif.busy), 128'h1);
    wait_valid(n);
    chk("b2b_latency", 128'(n), 128'd10);
    wait_idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
